// File: rtl/led_blink_driver.sv
// led_blink_driver: turns a single-cycle start event into N visible
// LED blinks with programmable on/off times and a completion pulse.
module led_blink_driver #(
    parameter int ON_CYCLES   = 12_500_000,
    parameter int OFF_CYCLES  = 12_500_000,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Start,
    input  logic [COUNT_WIDTH-1:0] i_Blinks,
    output logic                   o_LED,
    output logic                   o_Busy,
    output logic                   o_Done
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t                 r_State;
    state_t                 w_State_Next;
    logic [TW-1:0]          r_Timer;
    logic [TW-1:0]          w_Timer_Next;
    logic [COUNT_WIDTH-1:0] r_Remaining;
    logic [COUNT_WIDTH-1:0] w_Remaining_Next;
    logic                   r_LED;
    logic                   r_Busy;
    logic                   r_Done;
    logic                   w_LED_Next;
    logic                   w_Busy_Next;
    logic                   w_Done_Next;

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State     <= S_IDLE;
            r_Timer     <= '0;
            r_Remaining <= '0;
            r_LED       <= 1'b0;
            r_Busy      <= 1'b0;
            r_Done      <= 1'b0;
        end else begin
            r_State     <= w_State_Next;
            r_Timer     <= w_Timer_Next;
            r_Remaining <= w_Remaining_Next;
            r_LED       <= w_LED_Next;
            r_Busy      <= w_Busy_Next;
            r_Done      <= w_Done_Next;
        end
    end

    // Next-state and next-output logic; outputs follow the next state so
    // they appear registered in the same cycle the state takes effect.
    always_comb begin
        w_State_Next     = r_State;
        w_Timer_Next     = r_Timer;
        w_Remaining_Next = r_Remaining;
        w_Done_Next      = 1'b0;
        unique case (r_State)
            S_IDLE: begin
                w_Timer_Next = '0;
                if (i_Start && (i_Blinks != '0)) begin
                    w_State_Next     = S_ON;
                    w_Remaining_Next = i_Blinks;
                end
            end
            S_ON: begin
                if (r_Timer == ON_LAST) begin
                    w_Timer_Next = '0;
                    if (r_Remaining == COUNT_WIDTH'(1)) begin
                        // Last blink: no trailing dark gap.
                        w_State_Next     = S_IDLE;
                        w_Remaining_Next = '0;
                        w_Done_Next      = 1'b1;
                    end else begin
                        w_State_Next     = S_OFF;
                        w_Remaining_Next = r_Remaining - COUNT_WIDTH'(1);
                    end
                end else begin
                    w_Timer_Next = r_Timer + TW'(1);
                end
            end
            S_OFF: begin
                if (r_Timer == OFF_LAST) begin
                    w_Timer_Next = '0;
                    w_State_Next = S_ON;
                end else begin
                    w_Timer_Next = r_Timer + TW'(1);
                end
            end
            default: begin
                w_State_Next     = S_IDLE;
                w_Timer_Next     = '0;
                w_Remaining_Next = '0;
            end
        endcase
        w_LED_Next  = (w_State_Next == S_ON);
        w_Busy_Next = (w_State_Next != S_IDLE);
    end

    assign o_LED  = r_LED;
    assign o_Busy = r_Busy;
    assign o_Done = r_Done;

endmodule

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
Output-side counterpart of the switch debounce path. The debounce path turns a noisy human input into a clean single-cycle event. This block turns a single-cycle event into a human-visible LED pattern: N blinks with programmable on/off times. It sits between control logic (for example a debounced-switch edge detector) and a board LED pin.

Parameters:
ON_CYCLES, 12_500_000, clock cycles the LED is lit per blink (0.5 s at 25 MHz); must be >= 1
OFF_CYCLES, 12_500_000, clock cycles the LED is dark between consecutive blinks; must be >= 1
COUNT_WIDTH, 4, width of the blink-count request

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  synchronous, active-high reset
i_Start  input  1  single-cycle request to start a blink sequence
i_Blinks  input  COUNT_WIDTH  number of blinks requested; sampled only when i_Start is accepted
o_LED  output  1  LED drive, active high, registered
o_Busy  output  1  high while a sequence is in progress, registered
o_Done  output  1  one-cycle pulse when a sequence completes, registered

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On a clock edge with i_Rst=1: state=IDLE, o_LED=0, o_Busy=0, o_Done=0, all counters cleared. Reset mid-sequence aborts it with no o_Done pulse. i_Rst has priority over i_Start.
- States:
  - IDLE: LED off, not busy.
  - ON: LED lit for ON_CYCLES cycles.
  - OFF: LED dark for OFF_CYCLES cycles.
- IDLE -> ON:
  - Requires i_Start=1 and i_Blinks!=0 at an edge.
  - At that edge: latch remaining=i_Blinks, clear the timer, set o_LED=1 and o_Busy=1. Latency is 1 edge; outputs are visible the cycle after the request cycle.
- i_Start with i_Blinks=0 is ignored: no busy, no LED, no o_Done.
- ON:
  - o_LED=1 for exactly ON_CYCLES cycles.
  - At the end, if remaining>1: decrement remaining and go to OFF.
  - At the end, if remaining==1: go to IDLE. At that edge o_LED=0, o_Busy=0, o_Done=1 for one cycle.
- OFF:
  - o_LED=0 and o_Busy=1 for exactly OFF_CYCLES cycles, then go to ON.
  - No trailing OFF gap after the last blink.
- Total busy time for N blinks: N*ON_CYCLES + (N-1)*OFF_CYCLES cycles.
- i_Start while busy: ignored, no queuing. i_Start in the same cycle o_Done is high is accepted, because the state is already IDLE.
- i_Blinks changes after acceptance have no effect.
- The timer is wide enough for max(ON_CYCLES, OFF_CYCLES)-1 (clog2), and terminal count is compared against the parameter minus 1. The remaining-count decrement never wraps, because 0 is rejected at start.
- Maximum request is 2^COUNT_WIDTH-1 blinks (15 by default).

Test Plan:
- ON=3, OFF=2, i_Start with i_Blinks=2 at cycle 0 -> from cycle 1: o_LED=1,1,1,0,0,1,1,1 then 0. o_Busy high for cycles 1-8. o_Done=1 only at cycle 9.
- i_Blinks=1, ON=3 -> o_LED high cycles 1-3, o_Done at cycle 4, LED never blinks again.
- i_Start with i_Blinks=0 -> o_LED, o_Busy and o_Done stay 0 for 20 cycles.
- Sequence of 3 running, extra i_Start (i_Blinks=5) at cycle 4 -> ignored. Exactly 3 blinks and a single o_Done.
- i_Rst=1 during the second ON phase -> next edge o_LED=0, o_Busy=0, no o_Done. A subsequent i_Start with i_Blinks=1 gives a normal single blink.
- i_Start with i_Blinks=2 in the same cycle as o_Done -> new sequence starts next cycle: o_LED=1, o_Busy=1.
